// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: decodes stack opcodes into push/pop strobes, mirrors depth and traps faults
module stack_op_sequencer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [3:0]       instr_op,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [WIDTH-1:0] stk_data_a,
  input  logic [WIDTH-1:0] stk_data_b,
  output logic [WIDTH-1:0] stk_wr_data,
  output logic             stk_wr_en,
  output logic             stk_re_en_a,
  output logic             stk_re_en_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       depth,
  output logic             error,
  output logic [1:0]       err_code,
  input  logic             clear_err
);
  typedef enum logic [1:0] {IDLE, SWAP2, OUT_WAIT, ERROR} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_swap_a, r_out_data, w_alu_res;
  logic [4:0]       r_depth;
  logic [1:0]       r_err_code;
  logic             r_error, r_out_valid;
  logic             w_accept, w_push, w_pop, w_dup, w_swap, w_alu, w_out;
  logic             w_illegal, w_under, w_over, w_fault, w_go, w_inc, w_dec;

  assign instr_ready = reset_n & (r_state == IDLE);
  assign w_accept    = instr_valid & instr_ready;
  assign w_push      = instr_op == 4'h1;
  assign w_pop       = instr_op == 4'h2;
  assign w_dup       = instr_op == 4'h3;
  assign w_swap      = instr_op == 4'h4;
  assign w_alu       = instr_op >= 4'h5 && instr_op <= 4'h9;
  assign w_out       = instr_op == 4'hA;
  assign w_illegal   = instr_op > 4'hA;
  assign w_under     = ((w_swap | w_alu) & (r_depth < 5'd2)) | ((w_pop | w_dup | w_out) & (r_depth == 5'd0));
  assign w_over      = (w_push | w_dup) & (r_depth == 5'(DEPTH));
  assign w_fault     = w_illegal | w_under | w_over;
  assign w_go        = w_accept & ~w_fault;
  assign w_inc       = (w_go & (w_push | w_dup)) | (r_state == SWAP2);
  assign w_dec       = w_go & (w_pop | w_swap | w_alu | w_out);
  assign depth       = r_depth;
  assign error       = r_error;
  assign err_code    = r_err_code;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;

  // ALU result with a below top and b on top; wraps mod 2^WIDTH
  always_comb
    w_alu_res = instr_op == 4'h5 ? stk_data_a + stk_data_b :
                instr_op == 4'h6 ? stk_data_a - stk_data_b :
                instr_op == 4'h7 ? stk_data_a & stk_data_b :
                instr_op == 4'h8 ? stk_data_a | stk_data_b : stk_data_a ^ stk_data_b;

  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;

  // next-state decode
  always_comb
    case (r_state)
      IDLE:     w_next = !w_accept ? IDLE : w_fault ? ERROR : w_swap ? SWAP2 : w_out ? OUT_WAIT : IDLE;
      SWAP2:    w_next = IDLE;
      OUT_WAIT: w_next = out_ready ? IDLE : OUT_WAIT;
      default:  w_next = clear_err ? IDLE : ERROR;
    endcase

  // stack strobes, combinational in the accept cycle and in the second SWAP cycle
  always_comb begin
    stk_wr_en   = (w_go & (w_push | w_dup | w_swap | w_alu)) | (r_state == SWAP2);
    stk_re_en_b = w_dec;
    stk_re_en_a = w_go & (w_swap | w_alu);
    stk_wr_data = r_state == SWAP2 ? r_swap_a : !w_go ? '0 : w_push ? instr_imm :
                  (w_dup | w_swap) ? stk_data_b : w_alu ? w_alu_res : '0;
  end

  // depth mirror, swap latch, OUT holding register and sticky fault flags
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_depth     <= '0;
      r_swap_a    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_depth <= w_inc ? r_depth + 5'd1 : w_dec ? r_depth - 5'd1 : r_depth;
      if (w_go & w_swap) r_swap_a <= stk_data_a;
      if (w_go & w_out) begin
        r_out_data  <= stk_data_b;
        r_out_valid <= 1'b1;
      end else if (r_state == OUT_WAIT && out_ready) r_out_valid <= 1'b0;
      if (w_accept & w_fault) begin
        r_error    <= 1'b1;
        r_err_code <= w_illegal ? 2'd3 : w_under ? 2'd1 : 2'd2;
      end else if (r_state == ERROR && clear_err) begin
        r_error    <= 1'b0;
        r_err_code <= 2'd0;
      end
    end
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: randomized scoreboard bench with a queue-based stack reference model
module tb_stack_op_sequencer;
  localparam int D = 16;
  logic       clock = 0, reset_n = 0, instr_valid = 0, out_ready = 0, clear_err = 0;
  logic [3:0] instr_op = 0;
  logic [7:0] instr_imm = 0;
  logic [7:0] stk_data_a, stk_data_b, stk_wr_data, out_data;
  logic       instr_ready, stk_wr_en, stk_re_en_a, stk_re_en_b, out_valid, error;
  logic [4:0] depth;
  logic [1:0] err_code;
  int         n_cmp = 0, n_bad = 0;
  logic [7:0] mem [D];
  int         cnt;
  logic [7:0] ref_stk[$], exp_wr[$], exp_out[$];
  bit         rnd_ready = 1;

  always #5 clock = ~clock;

  stack_op_sequencer dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm), .stk_data_a(stk_data_a), .stk_data_b(stk_data_b),
    .stk_wr_data(stk_wr_data), .stk_wr_en(stk_wr_en), .stk_re_en_a(stk_re_en_a),
    .stk_re_en_b(stk_re_en_b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .depth(depth), .error(error), .err_code(err_code), .clear_err(clear_err));

  // environment stack the sequencer drives: pops first, then the push lands on the new top
  assign stk_data_b = cnt >= 1 && cnt <= D ? mem[cnt-1] : 8'h00;
  assign stk_data_a = cnt >= 2 && cnt <= D ? mem[cnt-2] : 8'h00;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cnt <= 0;
    else begin
      if (stk_wr_en && (cnt - int'(stk_re_en_a) - int'(stk_re_en_b)) inside {[0:D-1]})
        mem[cnt - int'(stk_re_en_a) - int'(stk_re_en_b)] <= stk_wr_data;
      cnt <= cnt - int'(stk_re_en_a) - int'(stk_re_en_b) + int'(stk_wr_en);
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expected stack writes and OUT results whenever the DUT presents them
  always @(negedge clock)
    if (reset_n) begin
      if (stk_re_en_a) chk("re_a_needs_re_b", {31'd0, stk_re_en_b}, 32'd1);
      if (stk_wr_en) begin
        if (exp_wr.size() == 0) chk("unexpected_wr_en", {31'd0, stk_wr_en}, 32'd0);
        else chk("wr_data", {24'd0, stk_wr_data}, {24'd0, exp_wr.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        else chk("out_data", {24'd0, out_data}, {24'd0, exp_out.pop_front()});
      end
    end

  initial forever begin
    @(posedge clock); #1;
    if (rnd_ready) out_ready = $urandom_range(0, 2) != 0;
  end

  // issue one instruction, update the reference model and check fault handling
  task automatic issue(input logic [3:0] op, input logic [7:0] imm);
    int n = 0, sz;
    logic [1:0] code;
    logic [7:0] a, b, r;
    @(posedge clock); #1;
    while (!instr_ready && n < 100) begin @(posedge clock); #1; n++; end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    sz = ref_stk.size();
    chk("depth", {27'd0, depth}, sz);
    chk("stack_count", cnt, sz);
    code = 0;
    if (op > 10) code = 3;
    else if ((op inside {2, 3, 10} && sz < 1) || (op inside {[4:9]} && sz < 2)) code = 1;
    else if (op inside {1, 3} && sz >= D) code = 2;
    b = sz > 0 ? ref_stk[sz-1] : 8'h00;
    a = sz > 1 ? ref_stk[sz-2] : 8'h00;
    instr_valid = 1; instr_op = op; instr_imm = imm;
    if (code == 0)
      case (op)
        1: begin ref_stk.push_back(imm); exp_wr.push_back(imm); end
        2: void'(ref_stk.pop_back());
        3: begin ref_stk.push_back(b); exp_wr.push_back(b); end
        4: begin ref_stk[sz-1] = a; ref_stk[sz-2] = b; exp_wr.push_back(b); exp_wr.push_back(a); end
        5, 6, 7, 8, 9: begin
          r = op == 5 ? a + b : op == 6 ? a - b : op == 7 ? a & b : op == 8 ? a | b : a ^ b;
          void'(ref_stk.pop_back()); void'(ref_stk.pop_back());
          ref_stk.push_back(r); exp_wr.push_back(r);
        end
        10: begin void'(ref_stk.pop_back()); exp_out.push_back(b); end
        default: ;
      endcase
    @(posedge clock); #1;
    instr_valid = 0;
    if (op == 4 && code == 0) chk("ready_low_in_swap2", {31'd0, instr_ready}, 32'd0);
    if (code != 0) begin
      chk("error_set", {31'd0, error}, 32'd1);
      chk("err_code", {30'd0, err_code}, {30'd0, code});
      chk("depth_hold_on_fault", {27'd0, depth}, sz);
      chk("ready_in_error", {31'd0, instr_ready}, 32'd0);
      clear_err = 1;
      @(posedge clock); #1;
      clear_err = 0;
      chk("error_cleared", {31'd0, error}, 32'd0);
      chk("err_code_cleared", {30'd0, err_code}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #12;
    chk("rst_depth", {27'd0, depth}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_err_code", {30'd0, err_code}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_strobes", {29'd0, stk_wr_en, stk_re_en_a, stk_re_en_b}, 32'd0);
    chk("rst_wr_data", {24'd0, stk_wr_data}, 32'd0);
    @(negedge clock); reset_n = 1;
    issue(1, 8'h05); issue(1, 8'h03); issue(6, 0); issue(10, 0);
    issue(1, 8'hF0); issue(1, 8'h20); issue(5, 0);
    @(negedge clock);
    chk("wrap_add_top", {24'd0, stk_data_b}, 32'h10);
    chk("wrap_add_depth", {27'd0, depth}, 32'd1);
    issue(10, 0);
    issue(1, 8'h01); issue(1, 8'h02); issue(4, 0); issue(10, 0); issue(10, 0);
    for (int i = 0; i < D; i++) issue(1, 8'($urandom));
    issue(1, 8'hAA);
    for (int i = 0; i < D; i++) issue(2, 0);
    issue(5, 0); issue(4'hC, 0); issue(3, 0);
    issue(0, 0);
    @(negedge clock); rnd_ready = 0; out_ready = 0;
    issue(1, 8'h77); issue(10, 0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", {24'd0, out_data}, 32'h77);
      chk("hold_ready_low", {31'd0, instr_ready}, 32'd0);
      @(posedge clock); #1;
    end
    #2 reset_n = 0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", {24'd0, out_data}, 32'd0);
    chk("arst_depth", {27'd0, depth}, 32'd0);
    chk("arst_strobes", {29'd0, stk_wr_en, stk_re_en_a, stk_re_en_b}, 32'd0);
    ref_stk.delete(); exp_out.delete();
    @(negedge clock); reset_n = 1; rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      issue(r < 5 ? 4'd1 : r < 16 ? 4'(r - 5) : 4'(r - 5), 8'($urandom));
    end
    @(negedge clock); rnd_ready = 0; out_ready = 1;
    issue(0, 0);
    repeat (3) @(posedge clock);
    chk("wr_queue_drained", exp_wr.size(), 32'd0);
    chk("out_queue_drained", exp_out.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
